// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch + data load/store) in front of one single-port RAM.
// A tag pipeline matched to the RAM read latency routes each read response back to its issuer.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 31,
  parameter int unsigned DATA_WIDTH      = 31,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_DATA_STREAK = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH:0]   i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH:0]   o_if_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [3:0]            i_d_be,
  input  logic [ADDR_WIDTH:0]   i_d_addr,
  input  logic [DATA_WIDTH:0]   i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH:0]   o_d_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic [DATA_WIDTH:0]   i_mem_rdata,
  output logic                  o_busy
);

  localparam logic [3:0] StreakMax = 4'(MAX_DATA_STREAK);

  logic                    w_en;
  logic                    w_if_win;
  logic                    w_d_win;
  logic                    w_rd;
  logic [3:0]              r_streak;
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_own;  // 1 = data requester, 0 = fetch

  assign w_en     = clk_en & rst;
  // Data has priority until it has starved a waiting fetch for StreakMax grants.
  assign w_d_win  = w_en & i_d_req & ~(i_if_req & (r_streak == StreakMax));
  assign w_if_win = w_en & i_if_req & ~w_d_win;
  assign w_rd     = w_if_win | (w_d_win & ~i_d_we);

  assign o_if_gnt = w_if_win;
  assign o_d_gnt  = w_d_win;
  assign o_mem_en = w_if_win | w_d_win;

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_if_win) begin
      o_mem_be   = 4'b1111;
      o_mem_addr = i_if_addr;
    end else if (w_d_win) begin
      o_mem_we    = i_d_we;
      o_mem_be    = i_d_be;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= 4'd0;
      r_vld    <= '0;
      r_own    <= '0;
    end else if (clk_en) begin
      if (!i_if_req || w_if_win) begin
        r_streak <= 4'd0;
      end else if (w_d_win && (r_streak != StreakMax)) begin
        r_streak <= r_streak + 4'd1;
      end
      r_vld[0] <= w_rd;
      r_own[0] <= w_d_win;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign o_if_rvalid = clk_en & r_vld[READ_LATENCY-1] & ~r_own[READ_LATENCY-1];
  assign o_d_rvalid  = clk_en & r_vld[READ_LATENCY-1] & r_own[READ_LATENCY-1];
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;
  assign o_busy      = |r_vld;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a RAM model plus a transaction-level reference
// (response queue with due times, golden memory, streak count) predicts every output.
module tb_mem_port_arbiter;

  localparam int AW = 31;
  localparam int DW = 31;
  localparam int RL = 2;
  localparam int MS = 2;

  logic          clk, rst, clk_en;
  logic          i_if_req;
  logic [AW:0]   i_if_addr;
  logic          o_if_gnt, o_if_rvalid;
  logic [DW:0]   o_if_rdata;
  logic          i_d_req, i_d_we;
  logic [3:0]    i_d_be;
  logic [AW:0]   i_d_addr;
  logic [DW:0]   i_d_wdata;
  logic          o_d_gnt, o_d_rvalid;
  logic [DW:0]   o_d_rdata;
  logic          o_mem_en, o_mem_we;
  logic [3:0]    o_mem_be;
  logic [AW:0]   o_mem_addr;
  logic [DW:0]   o_mem_wdata;
  logic [DW:0]   i_mem_rdata;
  logic          o_busy;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_DATA_STREAK(MS)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5C3_0000 ^ {4{8'(i * 17 + 3)}};
  endfunction

  // RAM model: 16 words indexed by addr[3:0], RL-cycle read pipe, same clock enable.
  logic [31:0] ram   [16];
  logic [31:0] rpipe [RL];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      for (int i = 0; i < RL; i++) rpipe[i] <= 32'h0;
    end else if (clk_en) begin
      if (o_mem_en && o_mem_we)
        for (int b = 0; b < 4; b++)
          if (o_mem_be[b]) ram[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      rpipe[0] <= ram[o_mem_addr[3:0]];
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign i_mem_rdata = rpipe[RL-1];

  // Reference model state
  typedef struct { bit own_d; logic [31:0] data; int due; } rsp_t;
  rsp_t        q[$];
  logic [31:0] gold [16];
  int          ecyc, streak;
  bit          if_acc, d_acc;
  bit          s_if_gnt, s_d_gnt, s_mem_we;
  logic [3:0]  s_mem_be;
  logic [31:0] s_mem_wdata;
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    streak = 0;
    if_acc = 0;
    d_acc  = 0;
    for (int i = 0; i < 16; i++) gold[i] = init_word(i);
  endtask

  // Called at the negedge: compare all outputs, then advance the model across the next edge.
  task automatic model_check();
    bit en, e_if, e_d, e_rvi, e_rvd;
    rsp_t r;
    en    = clk_en && rst;
    e_d   = en && i_d_req && !(i_if_req && streak == MS);
    e_if  = en && i_if_req && !e_d;
    e_rvi = clk_en && q.size() > 0 && q[0].due == ecyc && !q[0].own_d;
    e_rvd = clk_en && q.size() > 0 && q[0].due == ecyc && q[0].own_d;
    s_if_gnt = o_if_gnt; s_d_gnt = o_d_gnt; s_mem_we = o_mem_we;
    s_mem_be = o_mem_be; s_mem_wdata = o_mem_wdata;
    chk("if_gnt", 32'(o_if_gnt), 32'(e_if));
    chk("d_gnt", 32'(o_d_gnt), 32'(e_d));
    chk("mem_en", 32'(o_mem_en), 32'(e_if | e_d));
    if (e_if) begin
      chk("if_we", 32'(o_mem_we), 32'd0);
      chk("if_be", 32'(o_mem_be), 32'hF);
      chk("if_addr", o_mem_addr, i_if_addr);
    end else if (e_d) begin
      chk("d_we", 32'(o_mem_we), 32'(i_d_we));
      chk("d_be", 32'(o_mem_be), 32'(i_d_be));
      chk("d_addr", o_mem_addr, i_d_addr);
      if (i_d_we) chk("d_wdata", o_mem_wdata, i_d_wdata);
    end else begin
      chk("idle_we", 32'(o_mem_we), 32'd0);
    end
    chk("if_rvalid", 32'(o_if_rvalid), 32'(e_rvi));
    chk("d_rvalid", 32'(o_d_rvalid), 32'(e_rvd));
    if (e_rvi) chk("if_rdata", o_if_rdata, q[0].data);
    if (e_rvd) chk("d_rdata", o_d_rdata, q[0].data);
    chk("busy", 32'(o_busy), 32'(q.size() != 0));
    if_acc = e_if;
    d_acc  = e_d;
    if (en) begin
      if (q.size() > 0 && q[0].due == ecyc) void'(q.pop_front());
      if (e_if) begin
        r.own_d = 0; r.data = gold[i_if_addr[3:0]]; r.due = ecyc + RL; q.push_back(r);
      end else if (e_d && !i_d_we) begin
        r.own_d = 1; r.data = gold[i_d_addr[3:0]]; r.due = ecyc + RL; q.push_back(r);
      end else if (e_d) begin
        for (int b = 0; b < 4; b++)
          if (i_d_be[b]) gold[i_d_addr[3:0]][8*b +: 8] = i_d_wdata[8*b +: 8];
      end
      if (!i_if_req || e_if) streak = 0;
      else if (e_d && streak < MS) streak++;
      ecyc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    clk_en = ($urandom_range(0, 7) != 0);
    if (if_acc) i_if_req = 1'b0;
    if (!i_if_req && $urandom_range(0, 2) != 0) begin
      i_if_req  = 1'b1;
      i_if_addr = $urandom;
    end
    if (d_acc) i_d_req = 1'b0;
    if (!i_d_req && $urandom_range(0, 2) != 0) begin
      i_d_req   = 1'b1;
      i_d_we    = ($urandom_range(0, 2) == 0);
      i_d_be    = 4'($urandom_range(1, 15));
      i_d_addr  = $urandom;
      i_d_wdata = $urandom;
    end
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_addr = '0;
    i_d_req = 0; i_d_we = 0; i_d_be = 4'h0; i_d_addr = '0; i_d_wdata = '0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; ecyc = 0;
    rst = 1'b0; clk_en = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b1;

    // Randomized traffic with random clock-enable stalls
    for (int c = 0; c < 3000; c++) begin
      drive_rand();
      step();
    end

    // Let outstanding reads drain
    idle_inputs();
    clk_en = 1'b1;
    repeat (RL + 2) step();

    // Store with a single byte lane: no response, never busy
    i_d_req = 1; i_d_we = 1; i_d_be = 4'b0001; i_d_addr = 32'h200; i_d_wdata = 32'h0000_00AB;
    step();
    chk("st_we", 32'(s_mem_we), 32'd1);
    chk("st_be", 32'(s_mem_be), 32'h1);
    chk("st_wdata", s_mem_wdata, 32'hAB);
    idle_inputs();
    repeat (RL + 1) begin
      step();
      chk("st_busy", 32'(o_busy), 32'd0);
    end

    // Starvation: both requesting continuously; expect D,D,F repeating with MS=2
    i_if_req = 1; i_if_addr = 32'h10; i_d_req = 1; i_d_we = 0; i_d_be = 4'hF;
    i_d_addr = 32'h100;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("starve_f", 32'(s_if_gnt), 32'(k % 3 == 2));
      chk("starve_d", 32'(s_d_gnt), 32'(k % 3 != 2));
    end
    idle_inputs();
    repeat (RL + 1) step();

    // Asynchronous reset mid-cycle with a fetch read in flight
    i_if_req = 1; i_if_addr = 32'h40;
    step();
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(o_if_gnt | o_d_gnt), 32'd0);
    chk("arst_mem_en", 32'(o_mem_en), 32'd0);
    chk("arst_rvalid", 32'(o_if_rvalid | o_d_rvalid), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (RL + 3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: instruction fetch (read-only) and data load/store.
- Arbitrates one access per enabled cycle and forwards the winner's command to the RAM.
- Tracks in-flight reads in a tag pipeline, so each read response goes only to the requester that issued it.
- Sits between the core's fetch/load-store paths and the memory, replacing their separate direct RAM ports.

Parameters:
ADDR_WIDTH  31  MSB index of address buses (bus width = ADDR_WIDTH+1)
DATA_WIDTH  31  MSB index of data buses (bus width = DATA_WIDTH+1)
READ_LATENCY  1  RAM read latency in enabled cycles; legal range 1..4
MAX_DATA_STREAK  3  consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
clk_en  in  1  global clock enable; all state advances only when high
i_if_req  in  1  fetch read request
i_if_addr  in  ADDR_WIDTH+1  fetch address
o_if_gnt  out  1  fetch request accepted this cycle
o_if_rvalid  out  1  fetch read data valid
o_if_rdata  out  DATA_WIDTH+1  fetch read data
i_d_req  in  1  data request
i_d_we  in  1  1 = store, 0 = load
i_d_be  in  4  store/load byte enables
i_d_addr  in  ADDR_WIDTH+1  data address
i_d_wdata  in  DATA_WIDTH+1  store data
o_d_gnt  out  1  data request accepted this cycle
o_d_rvalid  out  1  load data valid
o_d_rdata  out  DATA_WIDTH+1  load data
o_mem_en  out  1  RAM access strobe
o_mem_we  out  1  RAM write enable
o_mem_be  out  4  RAM byte enables
o_mem_addr  out  ADDR_WIDTH+1  RAM address
o_mem_wdata  out  DATA_WIDTH+1  RAM write data
i_mem_rdata  in  DATA_WIDTH+1  RAM read data, READ_LATENCY enabled cycles after o_mem_en
o_busy  out  1  any read in flight

Behaviour:
Reset:
- rst low clears immediately, regardless of clk.
- Cleared: tag pipeline valid bits, streak counter, all gnt/rvalid/mem_en/mem_we outputs.
- Reads in flight at reset are dropped; no rvalid for them after rst rises.

Arbitration (combinational, evaluated each cycle):
- No grants and o_mem_en=0 while clk_en=0 or rst=0.
- Only one requester active: that requester wins.
- Both active: data wins, unless streak==MAX_DATA_STREAK, in which case fetch wins.
- Winner's gnt=1 in that cycle; loser's gnt=0.
- A requester holds req and all command fields stable until it sees gnt.

Streak counter:
- Updates on the enabled edge only.
- Increment: data granted while i_if_req=1.
- Clear: fetch granted, or i_if_req=0.
- Saturates at MAX_DATA_STREAK.

Memory command (winner's fields drive the RAM):
- Fetch: mem_we=0, mem_be=4'b1111, mem_addr=i_if_addr.
- Data: mem_we=i_d_we, mem_be=i_d_be, mem_addr=i_d_addr, mem_wdata=i_d_wdata.
- No winner: o_mem_en=0; other mem outputs are don't-care, driven 0.

Tag pipeline (READ_LATENCY stages, each {valid, owner}):
- Stage 0 loads {1, winner} on each enabled edge where a read is granted; otherwise {0, x}.
- Stores never enter the pipeline and produce no response.
- The pipeline shifts only when clk_en=1 and freezes otherwise, matching the RAM, which is gated by the same clk_en.
- Last stage drives rvalid: o_if_rvalid = valid & owner==fetch; o_d_rvalid = valid & owner==data.
- Both rvalid outputs are forced 0 while clk_en=0.
- Read issued in enabled cycle T produces rvalid in the READ_LATENCY-th following enabled cycle.
- o_if_rdata and o_d_rdata both pass i_mem_rdata through; consumers qualify with rvalid.
- Back-to-back reads: one response per enabled cycle, in issue order, no bubbles.
- o_busy = OR of all stage valid bits.

Edge cases:
- Simultaneous grant and response in the same cycle is legal.
- The arbiter never refuses a request for pipeline reasons; the pipeline never fills.

Test Plan:
- Reset: READ_LATENCY=2, fetch read in flight, pulse rst low mid-cycle -> all outputs 0 immediately; no o_if_rvalid in following cycles.
- Single fetch, READ_LATENCY=1: i_if_req=1, addr=0x40 -> same cycle o_if_gnt=1, o_mem_en=1, be=1111, addr=0x40; next cycle RAM returns 0xDEADBEEF -> o_if_rvalid=1, o_if_rdata=0xDEADBEEF, o_d_rvalid=0.
- Collision: fetch 0x10 and data load 0x100 asserted together -> data granted cycle 0, fetch granted cycle 1; o_d_rvalid in cycle 1, o_if_rvalid in cycle 2.
- Starvation, MAX_DATA_STREAK=2: both requesting continuously for 9 cycles -> grant sequence D,D,F,D,D,F,D,D,F.
- Store byte: i_d_we=1, be=0001, addr=0x200, wdata=0x000000AB -> o_mem_we=1, o_mem_be=0001, o_mem_wdata=0x000000AB; no rvalid ever; o_busy stays 0.
- clk_en freeze, READ_LATENCY=3: three back-to-back reads F,D,F, then clk_en low for 3 cycles -> no grants or rvalid during the stall; after resume, responses F,D,F are delivered in order on consecutive enabled cycles.
